// File: rtl/debounce_filter.sv
// debounce_filter: filters a bouncing 1-bit level input.
// A change on the sampled input must persist for STABLE_CYCLES consecutive
// rising clock edges before the registered output q follows it.
// rise/fall pulse for one cycle in the same cycle q changes.
// Optional build macro DEBOUNCE_SYNC_EN: din first passes through a two-flop
// synchroniser, which adds exactly two cycles of latency to q, rise and fall.
// dbg_state_o exposes the FSM state so external checkers can observe it.
module debounce_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic       q,
  output logic       rise,
  output logic       fall,
  output logic       pending,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  // Counter value on the edge that completes qualification.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             pending_q, pending_d;
  logic             s;

`ifdef DEBOUNCE_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchroniser for an asynchronous din.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  // din is already synchronous to clk; sample it directly.
  assign s = din;
`endif

  // State, counter and all outputs are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= STABLE_LO;
      cnt_q     <= CNT_ZERO;
      q_q       <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
    end
  end

  // Next state/counter; outputs are decoded from the next state so they
  // land in the same cycle as the state that defines them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = PEND_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      PEND_HI: begin
        if (!s) begin
          // Glitch: back to the old level without a pulse.
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = PEND_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      PEND_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = CNT_ZERO;
      end
    endcase
    q_d       = (state_d == STABLE_HI) || (state_d == PEND_LO);
    pending_d = (state_d == PEND_HI) || (state_d == PEND_LO);
  end

  assign q           = q_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign pending     = pending_q;
  assign dbg_state_o = state_q;

endmodule
